// File: rtl/sobel_window_feeder.sv
// Streams raster pixels into a 3-row circular line buffer and, for each complete 3x3 window,
// issues nine activation/weight pairs (Sobel Gx or Gy) to the downstream MAC.
module sobel_window_feeder #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  localparam int unsigned ColW = $clog2(IMG_W),
  localparam int unsigned RowW = $clog2(IMG_H)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pix_valid_i,
  input  logic [7:0]      pix_data_i,
  output logic            pix_ready_o,
  input  logic            kernel_sel_i,
  output logic            op_valid_o,
  output logic [7:0]      activation_o,
  output logic [7:0]      weight_o,
  output logic            acc_clear_o,
  output logic            win_last_o,
  output logic [RowW-1:0] out_row_o,
  output logic [ColW-1:0] out_col_o,
  output logic            frame_done_o
);

  typedef enum logic [1:0] {StIdle, StFill, StIssue} state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [1:0]      slot_q, slot_d;
  logic [3:0]      tap_q, tap_d;
  logic            ksel_q, ksel_d;
  logic            last_q, last_d;
  logic [7:0]      lb_q [3][IMG_W];
  logic [7:0]      win_q [9];
  logic [7:0]      win_d [9];
  logic [7:0]      win_c [9];

  logic            op_valid_q, op_valid_d;
  logic [7:0]      act_q, act_d;
  logic [7:0]      wt_q, wt_d;
  logic            clr_q, clr_d;
  logic            wlast_q, wlast_d;
  logic            fdone_q, fdone_d;
  logic [RowW-1:0] orow_q, orow_d;
  logic [ColW-1:0] ocol_q, ocol_d;

  logic accept, complete, col_end, row_end;

  function automatic logic [7:0] coef(logic ksel, logic [3:0] k);
    logic [7:0] w;
    w = 8'h00;
    if (!ksel) begin
      case (k)
        4'd0, 4'd6: w = 8'hFF;
        4'd2, 4'd8: w = 8'h01;
        4'd3:       w = 8'hFE;
        4'd5:       w = 8'h02;
        default:    w = 8'h00;
      endcase
    end else begin
      case (k)
        4'd0, 4'd2: w = 8'hFF;
        4'd1:       w = 8'hFE;
        4'd6, 4'd8: w = 8'h01;
        4'd7:       w = 8'h02;
        default:    w = 8'h00;
      endcase
    end
    return w;
  endfunction

  assign accept   = (state_q == StFill) && pix_valid_i;
  assign col_end  = (col_q == ColW'(IMG_W - 1));
  assign row_end  = (row_q == RowW'(IMG_H - 1));
  assign complete = accept && (col_q >= ColW'(2)) && (row_q >= RowW'(2));

  // Window view at the completing pixel; the bottom-right tap bypasses the buffer write.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_c[3*i+j] = lb_q[2'((int'(slot_q) + i + 1) % 3)][ColW'(int'(col_q) + j - 2)];
      end
    end
    win_c[8] = pix_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFill;
      StFill:  if (complete) state_d = StIssue;
      StIssue: if (tap_q == 4'd9) state_d = StFill;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    slot_d     = slot_q;
    tap_d      = tap_q;
    ksel_d     = ksel_q;
    last_d     = last_q;
    win_d      = win_q;
    op_valid_d = 1'b0;
    act_d      = 8'h00;
    wt_d       = 8'h00;
    clr_d      = 1'b0;
    wlast_d    = 1'b0;
    fdone_d    = 1'b0;
    orow_d     = orow_q;
    ocol_d     = ocol_q;

    if (accept) begin
      col_d = col_end ? '0 : col_q + 1'b1;
      if (col_end) begin
        row_d  = row_end ? '0 : row_q + 1'b1;
        slot_d = (row_end || slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
      end
    end

    if (complete) begin
      win_d      = win_c;
      ksel_d     = kernel_sel_i;
      last_d     = col_end && row_end;
      orow_d     = row_q - RowW'(2);
      ocol_d     = col_q - ColW'(2);
      op_valid_d = 1'b1;
      act_d      = win_c[0];
      wt_d       = coef(kernel_sel_i, 4'd0);
      clr_d      = 1'b1;
      tap_d      = 4'd1;
    end

    // tap_q == 9 is the trailing cycle that keeps input stalled while tap 8 is on the outputs
    if (state_q == StIssue) begin
      if (tap_q <= 4'd8) begin
        op_valid_d = 1'b1;
        act_d      = win_q[tap_q];
        wt_d       = coef(ksel_q, tap_q);
        wlast_d    = (tap_q == 4'd8);
        fdone_d    = (tap_q == 4'd8) && last_q;
        tap_d      = tap_q + 4'd1;
      end else begin
        tap_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q      <= '0;
      row_q      <= '0;
      slot_q     <= '0;
      tap_q      <= '0;
      ksel_q     <= 1'b0;
      last_q     <= 1'b0;
      op_valid_q <= 1'b0;
      act_q      <= 8'h00;
      wt_q       <= 8'h00;
      clr_q      <= 1'b0;
      wlast_q    <= 1'b0;
      fdone_q    <= 1'b0;
      orow_q     <= '0;
      ocol_q     <= '0;
      for (int k = 0; k < 9; k++) win_q[k] <= 8'h00;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      slot_q     <= slot_d;
      tap_q      <= tap_d;
      ksel_q     <= ksel_d;
      last_q     <= last_d;
      op_valid_q <= op_valid_d;
      act_q      <= act_d;
      wt_q       <= wt_d;
      clr_q      <= clr_d;
      wlast_q    <= wlast_d;
      fdone_q    <= fdone_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      win_q      <= win_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < 3; s++) begin
        for (int c = 0; c < int'(IMG_W); c++) lb_q[s][c] <= 8'h00;
      end
    end else if (accept) begin
      lb_q[slot_q][col_q] <= pix_data_i;
    end
  end

  assign pix_ready_o  = (state_q == StFill);
  assign op_valid_o   = op_valid_q;
  assign activation_o = act_q;
  assign weight_o     = wt_q;
  assign acc_clear_o  = clr_q;
  assign win_last_o   = wlast_q;
  assign frame_done_o = fdone_q;
  assign out_row_o    = orow_q;
  assign out_col_o    = ocol_q;

endmodule

// File: doc/sobel_window_feeder.md
# sobel_window_feeder

Operand producer for the approximate MAC path in the edge detector. Accepts a raster-order 8-bit pixel stream and keeps a 3-row circular line buffer. For every complete 3x3 window it issues the nine activation/weight pairs that the MAC consumes, together with the accumulator-clear and window-last markers. It sits between the pixel source and the MAC, and drives the MAC's activation and weight inputs.

## Interface
- IMG_W, 8, image width in pixels (>= 3)
- IMG_H, 8, image height in pixels (>= 3)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- pix_valid  in  1  pixel source has data
- pix_data  in  8  unsigned pixel
- pix_ready  out  1  feeder accepts a pixel; transfer when pix_valid & pix_ready at a rising edge
- kernel_sel  in  1  0 = Sobel Gx, 1 = Sobel Gy; sampled once per window
- op_valid  out  1  activation/weight pair valid this cycle
- activation  out  8  window pixel
- weight  out  8  two's-complement coefficient
- acc_clear  out  1  high with tap 0 of each window; the MAC starts a new sum
- win_last  out  1  high with tap 8 of each window
- out_row  out  $clog2(IMG_H)  output-pixel row of the current window
- out_col  out  $clog2(IMG_W)  output-pixel column of the current window
- frame_done  out  1  high with win_last of the final window of a frame

## Operation
- States: IDLE (reset), FILL, ISSUE.
  - IDLE -> FILL on the first edge after reset release.
  - FILL -> ISSUE when the accepted pixel completes a window.
  - ISSUE -> FILL after tap 8.
- pix_ready = (state == FILL). Only valid windows are produced: output pixel (r,c) uses rows r..r+2 and cols c..c+2, with r < IMG_H-2 and c < IMG_W-2. That is 36 windows for 8x8.
- A window completes on acceptance of pixel (r+2, c+2) with c+2 >= 2 and r+2 >= 2.
- Line buffer: 3 x IMG_W bytes, indexed by input row mod 3. Input is stalled during ISSUE, so an overwrite can never corrupt a pending window.
- Taps are issued row-major, k = 0..8. For tap k, activation = win[k/3][k%3].
  - Gx weights: FF,00,01,FE,00,02,FF,00,01.
  - Gy weights: FF,FE,FF,00,00,00,01,02,01.
- kernel_sel is latched in the acceptance cycle of the completing pixel and held for all nine taps.
- Tap 8 uses the just-accepted pixel. Implement a write-through bypass or register the window; a stale read is not allowed.
- Input position counters (col, row) wrap at IMG_W-1 and IMG_H-1. After the final pixel of a frame they return to 0, and the next frame starts clean with no state carried over.
- out_row/out_col hold the window coordinates through all nine taps.
- There is no downstream back-pressure: the MAC accepts one pair per cycle.

## Timing
- Reset values (reset low): state IDLE, pix_ready 0, op_valid 0, activation 00, weight 00, acc_clear 0, win_last 0, frame_done 0, out_row 0, out_col 0. Counters and latched kernel_sel are 0.
- All outputs except pix_ready are registered. pix_ready is decoded from the state register.
- Completing pixel accepted in cycle n:
  - op_valid is high in cycles n+1..n+9.
  - acc_clear is high in n+1.
  - win_last is high in n+9.
  - pix_ready is low in n+1..n+9 and high again in n+10.
- Non-completing pixels: pix_ready stays high, so back-to-back acceptance is allowed.
- Gaps on pix_valid simply hold FILL; the output sequence is unaffected.
- frame_done is a one-cycle pulse coincident with the final win_last.
- Reset asserted mid-ISSUE: outputs drop to reset values asynchronously, and the partial window is discarded with no completion markers. After release, the feeder waits one edge in IDLE before pix_ready rises.
- Throughput for 8x8: 64 accept cycles + 36 x 9 issue cycles = 388 cycles minimum per frame.

## Test plan
- Reset: assert reset during tap 4 of a window -> op_valid, acc_clear, win_last and activation are 0 immediately. After release, pix_ready is 0 for one cycle and then 1; the next frame starts at out_row/out_col 0.
- Ramp frame with kernel_sel=0, pix = 8*r + c, pix_valid held high:
  - first window appears after the 19th accepted pixel;
  - activations are 00,01,02,08,09,0A,10,11,12 with Gx weights;
  - the bench's signed sum is +8 for all 36 windows.
- Same ramp with kernel_sel=1 -> each window's signed sum is +64. Weights for tap 0..8 are FF,FE,FF,00,00,00,01,02,01.
- Handshake: pix_valid held high for the whole frame:
  - pix_ready drops for exactly 9 cycles after each completing pixel;
  - no pixel is lost or duplicated;
  - 64 transfers, 36 acc_clear, 36 win_last, and 1 frame_done coincident with window (5,5).
- Random pix_valid gaps plus kernel_sel toggled mid-window -> the op sequence is identical to the ungapped run. Weights switch only at the next window's tap 0.
- Two back-to-back frames -> the second frame's tap stream is identical to the first. There is no carry-over from the previous frame's rows.
